// File: rtl/console_pkg.sv
// Shared definitions for the text console: grid defaults, fill and cursor
// glyphs, recognised control codes, the console state type and the command
// set understood by the cursor tracker.
package console_pkg;

  localparam int         COLS_DEF     = 50;
  localparam int         ROWS_DEF     = 30;
  localparam logic [7:0] CLR_CHAR_DEF = 8'h20;
  localparam logic [7:0] CURSOR_GLYPH = 8'h5F;

  localparam logic [7:0] CODE_BS = 8'h08;
  localparam logic [7:0] CODE_LF = 8'h0A;
  localparam logic [7:0] CODE_FF = 8'h0C;
  localparam logic [7:0] CODE_CR = 8'h0D;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WRITE,
    ST_CURSOR
  } state_t;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_ADVANCE,
    CMD_NEWLINE,
    CMD_CR,
    CMD_BACK,
    CMD_HOME
  } cur_cmd_t;

endpackage

// File: rtl/console_cursor.sv
// Cursor tracker for the text console. Holds column, row and the linear cell
// address (row*COLS+col) side by side; the address is stepped incrementally
// so no multiplier is needed. All wrap behaviour (end of row, end of screen)
// lives here.
//   CLK_CPU  in   clock
//   resetn   in   asynchronous active-low reset (cursor home)
//   cmd      in   one command per cycle: advance/newline/cr/back/home/none
//   col      out  current column 0..COLS-1
//   row      out  current row 0..ROWS-1
//   addr     out  current linear cell address
module console_cursor
  import console_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic        CLK_CPU,
  input  logic        resetn,
  input  cur_cmd_t    cmd,
  output logic [5:0]  col,
  output logic [4:0]  row,
  output logic [10:0] addr
);

  localparam logic [5:0]  LAST_COL = 6'(COLS - 1);
  localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
  localparam logic [10:0] COLS_A   = 11'(COLS);

  always_ff @(posedge CLK_CPU or negedge resetn) begin
    if (!resetn) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else begin
      case (cmd)
        CMD_ADVANCE: begin
          if (col == LAST_COL) begin
            col <= '0;
            // Next cell after the last column is the start of the next row,
            // so addr+1 stays correct except at the very last cell.
            if (row == LAST_ROW) begin
              row  <= '0;
              addr <= '0;
            end else begin
              row  <= row + 5'd1;
              addr <= addr + 11'd1;
            end
          end else begin
            col  <= col + 6'd1;
            addr <= addr + 11'd1;
          end
        end
        CMD_NEWLINE: begin
          col <= '0;
          if (row == LAST_ROW) begin
            row  <= '0;
            addr <= '0;
          end else begin
            row  <= row + 5'd1;
            addr <= addr - 11'(col) + COLS_A;
          end
        end
        CMD_CR: begin
          col  <= '0;
          addr <= addr - 11'(col);
        end
        CMD_BACK: begin
          if (col != '0) begin
            col  <= col - 6'd1;
            addr <= addr - 11'd1;
          end
        end
        CMD_HOME: begin
          col  <= '0;
          row  <= '0;
          addr <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/text_console.sv
// Character-stream front end for video memory. Accepts ASCII bytes over a
// valid/ready handshake, tracks a text cursor on a COLS x ROWS grid and
// issues single-byte writes to video RAM. Handles CR, LF, BS and FF (clear).
// The whole screen is filled with CLR_CHAR after reset and after FF.
//   CLK_CPU             in   clock
//   resetn              in   asynchronous active-low reset
//   char_valid/char_data in  CPU byte stream
//   char_ready          out  high only in IDLE; transfer = valid && ready
//   video_write_enable  out  one-cycle write strobe
//   video_write_addr    out  linear cell address row*COLS+col
//   video_write_data    out  [7:0] glyph, [31:8] zero
//   cursor_col/row      out  current cursor position
// Optional feature: define TEXT_CONSOLE_CURSOR_EN for a visible underscore
// cursor (adds a CURSOR write cycle after each non-FF byte and after clear).
module text_console
  import console_pkg::*;
#(
  parameter int         COLS     = COLS_DEF,
  parameter int         ROWS     = ROWS_DEF,
  parameter logic [7:0] CLR_CHAR = CLR_CHAR_DEF
) (
  input  logic        CLK_CPU,
  input  logic        resetn,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic        video_write_enable,
  output logic [10:0] video_write_addr,
  output logic [31:0] video_write_data,
  output logic [5:0]  cursor_col,
  output logic [4:0]  cursor_row
);

  localparam logic [10:0] LAST_CELL = 11'(COLS * ROWS - 1);

  state_t      state;
  logic [10:0] clr_cnt;
  logic [7:0]  wr_byte;
  logic [10:0] cur_addr;
  cur_cmd_t    cmd;
  logic        transfer;
  logic        printable;
  logic [10:0] bs_addr;

  assign transfer         = (state == ST_IDLE) && char_ready && char_valid;
  assign printable        = (char_data >= 8'h20) && (char_data <= 8'h7E);
  assign bs_addr          = (cursor_col != '0) ? cur_addr - 11'd1 : cur_addr;
  assign video_write_data = {24'd0, wr_byte};

  // Cursor moves on the transfer edge itself, so its outputs are already
  // updated during the WRITE cycle.
  always_comb begin
    cmd = CMD_NONE;
    if (transfer) begin
      if (printable)                cmd = CMD_ADVANCE;
      else if (char_data == CODE_CR) cmd = CMD_CR;
      else if (char_data == CODE_LF) cmd = CMD_NEWLINE;
      else if (char_data == CODE_BS) cmd = CMD_BACK;
      else if (char_data == CODE_FF) cmd = CMD_HOME;
    end
  end

  console_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .CLK_CPU (CLK_CPU),
    .resetn  (resetn),
    .cmd     (cmd),
    .col     (cursor_col),
    .row     (cursor_row),
    .addr    (cur_addr)
  );

  always_ff @(posedge CLK_CPU or negedge resetn) begin
    if (!resetn) begin
      state              <= ST_CLEAR;
      clr_cnt            <= '0;
      char_ready         <= 1'b0;
      video_write_enable <= 1'b0;
      video_write_addr   <= '0;
      wr_byte            <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          video_write_enable <= 1'b1;
          video_write_addr   <= clr_cnt;
          wr_byte            <= CLR_CHAR;
          if (clr_cnt == LAST_CELL) begin
            clr_cnt <= '0;
`ifdef TEXT_CONSOLE_CURSOR_EN
            // WRITE's exit action draws the cursor at home.
            state   <= ST_WRITE;
`else
            state   <= ST_IDLE;
`endif
          end else begin
            clr_cnt <= clr_cnt + 11'd1;
          end
        end

        ST_IDLE: begin
          video_write_enable <= 1'b0;
          char_ready         <= 1'b1;
          if (transfer) begin
            char_ready <= 1'b0;
            state      <= ST_WRITE;
            wr_byte    <= CLR_CHAR;
            video_write_addr <= cur_addr;
            if (char_data == CODE_FF) begin
              state   <= ST_CLEAR;
              clr_cnt <= '0;
            end else if (printable) begin
              video_write_enable <= 1'b1;
              wr_byte            <= char_data;
`ifdef TEXT_CONSOLE_CURSOR_EN
            end else if (char_data == CODE_CR || char_data == CODE_LF ||
                         char_data == CODE_BS) begin
              // Erase the old cursor glyph; the new one follows in CURSOR.
              video_write_enable <= 1'b1;
`else
            end else if (char_data == CODE_BS) begin
              video_write_enable <= 1'b1;
              video_write_addr   <= bs_addr;
`endif
            end
          end
        end

        ST_WRITE: begin
`ifdef TEXT_CONSOLE_CURSOR_EN
          video_write_enable <= 1'b1;
          video_write_addr   <= cur_addr;
          wr_byte            <= CURSOR_GLYPH;
          state              <= ST_CURSOR;
`else
          video_write_enable <= 1'b0;
          char_ready         <= 1'b1;
          state              <= ST_IDLE;
`endif
        end

        default: begin
          video_write_enable <= 1'b0;
          char_ready         <= 1'b1;
          state              <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_console.sv
// Randomised self-checking bench for text_console with a behavioural model
// of the cursor grid and the expected stream of video RAM writes.
module tb_text_console;

  localparam int COLS  = 50;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
`ifdef TEXT_CONSOLE_CURSOR_EN
  localparam int CUR_EN = 1;
`else
  localparam int CUR_EN = 0;
`endif

  logic        CLK_CPU = 1'b0;
  logic        resetn = 1'b0;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        char_ready;
  logic        video_write_enable;
  logic [10:0] video_write_addr;
  logic [31:0] video_write_data;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;

  text_console dut (
    .CLK_CPU            (CLK_CPU),
    .resetn             (resetn),
    .char_valid         (char_valid),
    .char_data          (char_data),
    .char_ready         (char_ready),
    .video_write_enable (video_write_enable),
    .video_write_addr   (video_write_addr),
    .video_write_data   (video_write_data),
    .cursor_col         (cursor_col),
    .cursor_row         (cursor_row)
  );

  always #5 CLK_CPU = ~CLK_CPU;

  int tests = 0;
  int fails = 0;
  int hi_bad = 0;

  int mcol = 0;
  int mrow = 0;
  logic [18:0] exp_q[$];
  logic [18:0] act_q[$];
  logic        wr_en_seen;
  logic [10:0] wr_addr_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor
  always @(negedge CLK_CPU) begin
    if (video_write_enable === 1'b1) begin
      act_q.push_back({video_write_addr, video_write_data[7:0]});
      if (video_write_data[31:8] !== 24'd0) hi_bad++;
    end
  end

  function automatic void push_w(input int a, input logic [7:0] d);
    exp_q.push_back({11'(a), d});
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < CELLS; i++) push_w(i, 8'h20);
    mcol = 0;
    mrow = 0;
    if (CUR_EN != 0) push_w(0, 8'h5F);
  endfunction

  function automatic void model_apply(input logic [7:0] b);
    int old;
    old = mrow * COLS + mcol;
    if (b == 8'h0C) begin
      model_clear();
      return;
    end
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_w(old, b);
      mcol++;
      if (mcol == COLS) begin
        mcol = 0;
        mrow = (mrow + 1) % ROWS;
      end
    end else if (b == 8'h0D) begin
      if (CUR_EN != 0) push_w(old, 8'h20);
      mcol = 0;
    end else if (b == 8'h0A) begin
      if (CUR_EN != 0) push_w(old, 8'h20);
      mcol = 0;
      mrow = (mrow + 1) % ROWS;
    end else if (b == 8'h08) begin
      if (mcol > 0) mcol--;
      push_w((CUR_EN != 0) ? old : mrow * COLS + mcol, 8'h20);
    end else begin
      return;
    end
    if (CUR_EN != 0) push_w(mrow * COLS + mcol, 8'h5F);
  endfunction

  task automatic wait_ready(input string tag, output int n);
    n = 0;
    do begin
      @(negedge CLK_CPU);
      n++;
    end while (char_ready !== 1'b1 && n < 5000);
    if (char_ready !== 1'b1) check({tag, "_ready_timeout"}, 0, 1);
  endtask

  task automatic compare_writes(input string tag);
    int bad;
    int n;
    repeat (4) @(negedge CLK_CPU);
    check({tag, "_count"}, act_q.size(), exp_q.size());
    bad = 0;
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (act_q[i] !== exp_q[i]) begin
        if (bad == 0)
          $display("  first difference in %s at %0d: got %h, expected %h", tag, i, act_q[i], exp_q[i]);
        bad++;
      end
    end
    check({tag, "_writes"}, bad, 0);
    act_q.delete();
    exp_q.delete();
  endtask

  // Present one byte; optionally keep valid high with a follow-up byte.
  task automatic send_byte(input string tag, input logic [7:0] b,
                           input bit hold, input logic [7:0] nxt);
    int n;
    if (char_ready !== 1'b1) wait_ready(tag, n);
    else @(negedge CLK_CPU);
    if (char_ready !== 1'b1) wait_ready(tag, n);
    char_valid = 1'b1;
    char_data  = b;
    @(posedge CLK_CPU);
    #1;
    if (hold) char_data = nxt;
    else char_valid = 1'b0;
    model_apply(b);
    @(negedge CLK_CPU);
    wr_en_seen   = video_write_enable;
    wr_addr_seen = video_write_addr;
    if (b != 8'h0C) begin
      check({tag, "_col"}, cursor_col, mcol);
      check({tag, "_row"}, cursor_row, mrow);
    end
    check({tag, "_busy"}, char_ready, 0);
  endtask

  initial begin
    int n;
    logic [7:0] b;
    int r;

    // Reset state
    #12;
    check("rst_we", video_write_enable, 0);
    check("rst_addr", video_write_addr, 0);
    check("rst_data", video_write_data, 0);
    check("rst_ready", char_ready, 0);
    check("rst_cursor", {cursor_row, cursor_col}, 0);

    // Power-up clear
    @(negedge CLK_CPU);
    resetn = 1'b1;
    model_clear();
    wait_ready("init", n);
    check("init_latency", n, CELLS + 1 + CUR_EN);
    check("init_cursor", {cursor_row, cursor_col}, 0);
    compare_writes("init");

    // "AB"
    send_byte("A", 8'h41, 0, 8'h00);
    check("A_we", wr_en_seen, 1);
    check("A_addr", wr_addr_seen, 0);
    send_byte("B", 8'h42, 0, 8'h00);
    check("B_addr", wr_addr_seen, 1);
    check("AB_col", cursor_col, 2);
    compare_writes("ab");

    // End-of-row wrap: from (2,0) to (49,0), then 'X'
    for (int i = 0; i < 47; i++) send_byte("fill0", 8'h61, 0, 8'h00);
    send_byte("xrow", 8'h58, 0, 8'h00);
    check("xrow_addr", wr_addr_seen, 49);
    check("xrow_pos", {cursor_row, cursor_col}, {5'd1, 6'd0});
    // To (49,29) then 'X' wraps the whole screen
    for (int i = 0; i < 28; i++) send_byte("lf", 8'h0A, 0, 8'h00);
    for (int i = 0; i < 49; i++) send_byte("fill29", 8'h62, 0, 8'h00);
    send_byte("xend", 8'h58, 0, 8'h00);
    check("xend_addr", wr_addr_seen, 1499);
    check("xend_pos", {cursor_row, cursor_col}, 0);
    compare_writes("wrap");

    // (5,3): LF, BS, BS
    for (int i = 0; i < 3; i++) send_byte("lf3", 8'h0A, 0, 8'h00);
    for (int i = 0; i < 5; i++) send_byte("c5", 8'h63, 0, 8'h00);
    send_byte("lf53", 8'h0A, 0, 8'h00);
    check("lf53_pos", {cursor_row, cursor_col}, {5'd4, 6'd0});
    check("lf53_we", wr_en_seen, CUR_EN);
    send_byte("bs0a", 8'h08, 0, 8'h00);
    check("bs0a_we", wr_en_seen, 1);
    check("bs0a_addr", wr_addr_seen, 200);
    send_byte("bs0b", 8'h08, 0, 8'h00);
    check("bs0b_pos", {cursor_row, cursor_col}, {5'd4, 6'd0});
    compare_writes("bs");

    // Randomised mix of bytes
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) b = 8'($urandom_range(32, 126));
      else if (r == 6) b = 8'h0D;
      else if (r == 7) b = 8'h0A;
      else if (r == 8) b = 8'h08;
      else begin
        do b = 8'($urandom_range(0, 255));
        while ((b >= 8'h20 && b <= 8'h7E) || b == 8'h0C || b == 8'h0D || b == 8'h0A || b == 8'h08);
      end
      send_byte("rnd", b, 0, 8'h00);
      if (i % 25 == 24) compare_writes("rnd");
    end

    // FF with valid held for 'Z'
    send_byte("ff", 8'h0C, 1, 8'h5A);
    wait_ready("ffz", n);
    @(posedge CLK_CPU);
    #1 char_valid = 1'b0;
    model_apply(8'h5A);
    @(negedge CLK_CPU);
    check("z_pos", {cursor_row, cursor_col}, {5'd0, 6'd1});
    compare_writes("ffz");

    // Reset in the middle of a clear
    send_byte("ff2", 8'h0C, 0, 8'h00);
    n = 0;
    while (!(video_write_enable === 1'b1 && video_write_addr == 11'd700) && n < 3000) begin
      @(negedge CLK_CPU);
      n++;
    end
    check("mid_clear_reached", video_write_addr, 700);
    @(posedge CLK_CPU);
    #2 resetn = 1'b0;
    #1;
    check("midrst_we", video_write_enable, 0);
    check("midrst_addr", video_write_addr, 0);
    check("midrst_data", video_write_data, 0);
    check("midrst_ready", char_ready, 0);
    repeat (3) @(negedge CLK_CPU);
    act_q.delete();
    exp_q.delete();
    resetn = 1'b1;
    model_clear();
    wait_ready("restart", n);
    check("restart_latency", n, CELLS + 1 + CUR_EN);
    compare_writes("restart");

    check("data_hi_zero", hi_bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
